// File: rtl/seq_mult4_pkg.sv
// Shared widths and FSM encoding for the seq_mult4 sequential multiplier.
package seq_mult4_pkg;

    localparam int unsigned W     = 4;
    localparam int unsigned PW    = 8;
    localparam int unsigned ITERS = 4;
    localparam int unsigned CW    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult4_if.sv
// Operand/result handshake bundle between an upstream requester and seq_mult4.
interface seq_mult4_if;
    import seq_mult4_pkg::*;

    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    modport master (output start, output a, output b,
                    input busy, input done, input product);
    modport slave  (input start, input a, input b,
                    output busy, output done, output product);

endinterface

// File: rtl/seq_mult4_fulladder4b.sv
// fulladder4b: 4-bit ripple-carry adder reused as the multiplier's accumulator adder.
module fulladder4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);

    logic [4:0] c;

    // Ripple the carry bit by bit through four full-adder cells.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carry = c[4];
    end

endmodule

// File: rtl/seq_mult4.sv
// seq_mult4: 4x4 unsigned shift-and-add multiplier, one adder pass per cycle.
// Optional feature: define SEQ_MULT4_ZERO_BYPASS_EN to skip CALC when an operand is zero.
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    seq_mult4_if.slave bus
);

    state_t        state_q, state_n;
    logic [W-1:0]  mcand_q, mcand_n;
    logic [PW-1:0] p_q, p_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          busy_q, done_q;
    logic [W-1:0]  add_sum;
    logic          add_carry;

    fulladder4b u_add (
        .a     (p_q[PW-1:W]),
        .b     (mcand_q),
        .cin   (1'b0),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Next-state and datapath update: accept in IDLE, shift/add in CALC, one-cycle DONE.
    always_comb begin
        state_n = state_q;
        mcand_n = mcand_q;
        p_n     = p_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_n = bus.a;
                    p_n     = {W'(0), bus.b};
                    cnt_n   = '0;
                    state_n = CALC;
`ifdef SEQ_MULT4_ZERO_BYPASS_EN
                    if ((bus.a == '0) || (bus.b == '0)) begin
                        p_n     = '0;
                        state_n = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (p_q[0]) begin
                    p_n = {add_carry, add_sum, p_q[W-1:1]};
                end else begin
                    p_n = {1'b0, p_q[PW-1:1]};
                end
                cnt_n = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            mcand_q <= mcand_n;
            p_q     <= p_n;
            cnt_q   <= cnt_n;
            busy_q  <= (state_n == CALC);
            done_q  <= (state_n == DONE);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = p_q;

endmodule

// File: tb/tb_seq_mult4.sv
// Scoreboard bench for seq_mult4: stimulus queues expected products, a monitor checks them on done.
module tb_seq_mult4;
    import seq_mult4_pkg::*;

    logic clk = 1'b0;
    logic rst;

    seq_mult4_if bus ();

    seq_mult4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  expq[$];
    logic [7:0]  exp_v;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every done strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (expq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_done: got product %0d expected no done", bus.product);
            end else begin
                exp_v = expq.pop_front();
                check("product", int'(bus.product), int'(exp_v));
            end
            check("done_strobe_len", int'(prev_done), 0);
        end
        prev_done = bus.done & ~rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((bus.busy || bus.done) && k < 20) begin
            tick();
            k++;
        end
        if (bus.busy || bus.done) check("idle_timeout", int'(bus.busy | bus.done), 0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        if (!bus.done) check("done_timeout", int'(bus.done), 1);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] expv,
                          input int lat, input int busy_exp);
        int n;
        wait_idle();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        expq.push_back(expv);
        tick();
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), busy_exp);
        wait_done(n);
        check("latency", n, lat);
        check("busy_at_done", int'(bus.busy), 0);
    endtask

    logic [3:0] ta [10] = '{4'd7, 4'd12, 4'd1, 4'd10, 4'd13, 4'd4, 4'd8, 4'd11, 4'd5, 4'd14};
    logic [3:0] tb_ [10] = '{4'd9, 4'd11, 4'd15, 4'd10, 4'd6, 4'd14, 4'd8, 4'd3, 4'd12, 4'd13};
    logic [7:0] tp [10] = '{8'd63, 8'd132, 8'd15, 8'd100, 8'd78, 8'd56, 8'd64, 8'd33, 8'd60, 8'd182};

    // Directed stimulus sequence.
    initial begin
        int n;
        int gap;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) tick();
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_product", int'(bus.product), 0);
        rst = 1'b0;

        run_op(4'd3, 4'd5, 8'd15, 4, 1);
        run_op(4'd15, 4'd15, 8'd225, 4, 1);
`ifdef SEQ_MULT4_ZERO_BYPASS_EN
        run_op(4'd0, 4'd9, 8'd0, 0, 0);
`else
        run_op(4'd0, 4'd9, 8'd0, 4, 1);
`endif

        // start held through CALC/DONE: only the IDLE-cycle request is taken
        wait_idle();
        bus.start = 1'b1;
        bus.a     = 4'd6;
        bus.b     = 4'd7;
        expq.push_back(8'd42);
        tick();
        bus.a = 4'd2;
        bus.b = 4'd2;
        check("busy_after_start", int'(bus.busy), 1);
        wait_done(n);
        check("latency", n, 4);
        expq.push_back(8'd4);
        gap = 0;
        while (!bus.busy && gap < 20) begin
            tick();
            gap++;
        end
        check("restart_gap", gap, 2);
        bus.start = 1'b0;
        wait_done(n);
        check("latency", n, 4);

        // reset asserted at E2 of a 9x9 aborts it
        wait_idle();
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd9;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_product", int'(bus.product), 0);
        rst = 1'b0;
        repeat (6) tick();
        check("product_after_abort", int'(bus.product), 0);
        run_op(4'd9, 4'd9, 8'd81, 4, 1);

        for (int i = 0; i < 10; i++) begin
            run_op(ta[i], tb_[i], tp[i], 4, 1);
        end

        repeat (3) tick();
        check("queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
